fetch_redirect: RTL and testbench
=================================

FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16, width of the saturating redirect counter.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port branch  input  1  taken-branch decision from the branch comparator (EX stage), valid same cycle as target.
REQ-006 Port jump  input  1  unconditional redirect (JAL/JALR) from EX stage.
REQ-007 Port target  input  32  redirect destination, qualified by branch|jump.
REQ-008 Port stall  input  1  hazard stall from decode; holds PC.
REQ-009 Port imem_ready  input  1  instruction memory accepts the current request this cycle.
REQ-010 Port pc  output  32  fetch address presented to instruction memory.
REQ-011 Port pc_plus4  output  32  pc+4, combinational from pc, modulo 2^32.
REQ-012 Port imem_req  output  1  fetch request valid.
REQ-013 Port flush_if  output  1  squash IF/ID register.
REQ-014 Port flush_id  output  1  squash ID/EX register.
REQ-015 Port misalign  output  1  one-cycle pulse: redirect target not word-aligned.
REQ-016 Port redirect_cnt  output  CNT_W  count of accepted redirects.

Function
REQ-017 States SHALL be BOOT, FETCH, HOLD, REDIRECT; encoded 2 bits.
REQ-018 BOOT: imem_req=0, pc=RESET_PC; SHALL go to FETCH next cycle unconditionally.
REQ-019 FETCH: imem_req=1; if imem_ready & !stall, pc <= pc+4 and stay FETCH; else go HOLD, pc unchanged.
REQ-020 HOLD: imem_req=1, pc unchanged; return to FETCH (pc <= pc+4) the first cycle imem_ready & !stall.
REQ-021 A redirect is accepted when (branch|jump) and target[1:0]==2'b00, in FETCH or HOLD.
REQ-022 Accepted redirect: pc <= target next edge, state <= REDIRECT, regardless of stall or imem_ready (redirect wins over stall).
REQ-023 REDIRECT: lasts exactly one cycle; flush_if=1 and flush_id=1 registered outputs asserted in this cycle only; imem_req=1 at new pc; next state FETCH/HOLD per REQ-019 rule.
REQ-024 flush_if/flush_id SHALL be 0 in every other state.
REQ-025 branch|jump with target[1:0]!=0: redirect rejected, pc follows REQ-019/020 as if no redirect, misalign=1 for the following cycle, no flush, counter unchanged.
REQ-026 branch|jump asserted during REDIRECT or BOOT SHALL be ignored (younger wrong-path instruction).
REQ-027 branch and jump both high is one redirect to target; counted once.
REQ-028 redirect_cnt increments by 1 per accepted redirect; saturates at all-ones, no wrap.
REQ-029 PC increment wraps: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
REQ-030 Latency: redirect accepted in cycle N -> pc==target and flushes high in cycle N+1.

Reset
REQ-031 rst high at an edge: state=BOOT, pc=RESET_PC, imem_req=0, flush_if=0, flush_id=0, misalign=0, redirect_cnt=0.
REQ-032 rst overrides all inputs including a simultaneous redirect; reset mid-REDIRECT or mid-HOLD discards pending state.
REQ-033 Reset value of RESET_PC SHALL be word-aligned; low 2 bits forced to 0.

Structure
REQ-034 State encoding constants and the 32-bit instruction-width constant SHALL live in the shared CPU package/header.
REQ-035 The saturating counter SHALL be a sub-module sat_counter (parameter width, inputs clk, rst, inc; output count).
REQ-036 Remaining logic (FSM, PC register, adder) in fetch_redirect; no latches, single always block per register group.

Verification
REQ-037 Reset then 3 cycles, imem_ready=1, stall=0 -> pc sequence 0,0,4,8; imem_req 0,1,1,1.
REQ-038 In FETCH at pc=0x10, branch=1, target=0x40, stall=1 same cycle -> next cycle pc=0x40, flush_if=flush_id=1, redirect_cnt=1; cycle after flushes 0, pc=0x44.
REQ-039 jump=1, target=0x42 -> no redirect, misalign=1 for one cycle, pc advances +4, redirect_cnt unchanged.
REQ-040 pc=0xFFFF_FFFC, imem_ready=1 -> next pc=0x0000_0000; imem_ready=0 for 2 cycles -> HOLD, pc steady, imem_req=1.
REQ-041 CNT_W=2, four accepted redirects spaced 2 cycles -> redirect_cnt 1,2,3,3; branch during REDIRECT cycle ignored.
REQ-042 rst asserted in REDIRECT cycle with branch=1 -> next cycle pc=RESET_PC, flushes 0, redirect_cnt 0, state BOOT.

Source files
------------

// File: rtl/fetch_redirect_pkg.sv
// Shared CPU fetch definitions: instruction width and fetch FSM state encoding.
package fetch_redirect_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        HOLD     = 2'd2,
        REDIRECT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_sat_counter.sv
// Saturating up-counter: advances by one per inc pulse and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch-stage PC sequencer: sequential fetch, stall/hold handling and EX-stage
// redirects with pipeline flush, misalignment pulse and a redirect counter.
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch,
    input  logic               jump,
    input  logic [INSTR_W-1:0] target,
    input  logic               stall,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus4,
    output logic               imem_req,
    output logic               flush_if,
    output logic               flush_id,
    output logic               misalign,
    output logic [CNT_W-1:0]   redirect_cnt
);

    localparam logic [INSTR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_t       state_reg, state_next;
    logic [INSTR_W-1:0] pc_reg, pc_next;
    logic               flush_reg;
    logic               misalign_reg;
    logic               accept;
    logic               reject;
    logic               advance;
    logic               redirect_req;

    assign advance      = imem_ready & ~stall;
    assign redirect_req = branch | jump;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        unique case (state_reg)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH, HOLD: begin
                if (redirect_req && (target[1:0] == 2'b00)) begin
                    accept     = 1'b1;
                    pc_next    = target;
                    state_next = REDIRECT;
                end else begin
                    reject = redirect_req;
                    if (advance) begin
                        pc_next    = pc_plus4;
                        state_next = FETCH;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            REDIRECT: begin
                // Redirect requests here come from wrong-path instructions.
                if (advance) begin
                    pc_next    = pc_plus4;
                    state_next = FETCH;
                end else begin
                    state_next = HOLD;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC_ALIGNED;
            flush_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            flush_reg    <= accept;
            misalign_reg <= reject;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .count (redirect_cnt)
    );

    assign pc       = pc_reg;
    assign pc_plus4 = pc_reg + 32'd4;
    assign imem_req = (state_reg != BOOT);
    assign flush_if = flush_reg;
    assign flush_id = flush_reg;
    assign misalign = misalign_reg;

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: vector table plus counter-saturation and
// reset-alignment sequences on a narrow-counter instance.
module tb_fetch_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch;
    logic        jump;
    logic [31:0] target;
    logic        stall;
    logic        imem_ready;

    logic [31:0] a_pc, a_pc_plus4;
    logic        a_req, a_fif, a_fid, a_mis;
    logic [15:0] a_cnt;
    logic [31:0] b_pc, b_pc_plus4;
    logic        b_req, b_fif, b_fid, b_mis;
    logic [1:0]  b_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_redirect dut_a (
        .clk(clk), .rst(rst), .branch(branch), .jump(jump), .target(target),
        .stall(stall), .imem_ready(imem_ready),
        .pc(a_pc), .pc_plus4(a_pc_plus4), .imem_req(a_req),
        .flush_if(a_fif), .flush_id(a_fid), .misalign(a_mis), .redirect_cnt(a_cnt)
    );

    fetch_redirect #(.RESET_PC(32'h0000_1003), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .branch(branch), .jump(jump), .target(target),
        .stall(stall), .imem_ready(imem_ready),
        .pc(b_pc), .pc_plus4(b_pc_plus4), .imem_req(b_req),
        .flush_if(b_fif), .flush_id(b_fid), .misalign(b_mis), .redirect_cnt(b_cnt)
    );

    typedef struct packed {
        logic        rst;
        logic        branch;
        logic        jump;
        logic        stall;
        logic        ready;
        logic [31:0] target;
        logic [31:0] pc;
        logic        req;
        logic        flush;
        logic        mis;
        logic [15:0] cnt;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic b, input logic j,
                                input logic s, input logic rdy, input logic [31:0] t,
                                input logic [31:0] p, input logic rq, input logic fl,
                                input logic m, input logic [15:0] c);
        vec_t v;
        v.rst = r; v.branch = b; v.jump = j; v.stall = s; v.ready = rdy; v.target = t;
        v.pc = p; v.req = rq; v.flush = fl; v.mis = m; v.cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic b, input logic j, input logic s,
                         input logic rdy, input logic [31:0] t);
        rst = r; branch = b; jump = j; stall = s; imem_ready = rdy; target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; branch = 1'b0; jump = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        target = 32'h0;

        //             rst br jp st rdy target         pc             rq fl ms cnt
        vecs[0]  = mk(1, 0, 0, 0, 1, 32'h0,         32'h0000_0000, 0, 0, 0, 16'd0);
        vecs[1]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h0000_0000, 1, 0, 0, 16'd0);
        vecs[2]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h0000_0004, 1, 0, 0, 16'd0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h0000_0008, 1, 0, 0, 16'd0);
        vecs[4]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h0000_000C, 1, 0, 0, 16'd0);
        vecs[5]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h0000_0010, 1, 0, 0, 16'd0);
        vecs[6]  = mk(0, 1, 0, 1, 1, 32'h40,        32'h0000_0040, 1, 1, 0, 16'd1);
        vecs[7]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h0000_0044, 1, 0, 0, 16'd1);
        vecs[8]  = mk(0, 0, 1, 0, 1, 32'h42,        32'h0000_0048, 1, 0, 1, 16'd1);
        vecs[9]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h0000_004C, 1, 0, 0, 16'd1);
        vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_004C, 1, 0, 0, 16'd1);
        vecs[11] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_004C, 1, 0, 0, 16'd1);
        vecs[12] = mk(0, 0, 0, 1, 1, 32'h0,         32'h0000_004C, 1, 0, 0, 16'd1);
        vecs[13] = mk(0, 0, 0, 0, 1, 32'h0,         32'h0000_0050, 1, 0, 0, 16'd1);
        vecs[14] = mk(0, 1, 1, 0, 0, 32'h100,       32'h0000_0100, 1, 1, 0, 16'd2);
        vecs[15] = mk(0, 1, 0, 0, 1, 32'h200,       32'h0000_0104, 1, 0, 0, 16'd2);
        vecs[16] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_0104, 1, 0, 0, 16'd2);
        vecs[17] = mk(0, 0, 1, 1, 0, 32'h300,       32'h0000_0300, 1, 1, 0, 16'd3);
        vecs[18] = mk(1, 1, 0, 0, 1, 32'h400,       32'h0000_0000, 0, 0, 0, 16'd0);
        vecs[19] = mk(0, 1, 0, 0, 1, 32'h80,        32'h0000_0000, 1, 0, 0, 16'd0);
        vecs[20] = mk(0, 0, 1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 0, 16'd1);
        vecs[21] = mk(0, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 0, 16'd1);
        vecs[22] = mk(0, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 0, 16'd1);
        vecs[23] = mk(0, 0, 0, 0, 1, 32'h0,         32'h0000_0000, 1, 0, 0, 16'd1);
        vecs[24] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 0, 16'd1);
        vecs[25] = mk(0, 1, 0, 0, 0, 32'h41,        32'h0000_0000, 1, 0, 1, 16'd1);
        vecs[26] = mk(0, 0, 0, 0, 1, 32'h0,         32'h0000_0004, 1, 0, 0, 16'd1);
        vecs[27] = mk(0, 0, 1, 0, 1, 32'h500,       32'h0000_0500, 1, 1, 0, 16'd2);
        vecs[28] = mk(0, 1, 0, 0, 1, 32'h503,       32'h0000_0504, 1, 0, 0, 16'd2);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].branch, vecs[i].jump, vecs[i].stall,
                  vecs[i].ready, vecs[i].target);
            $display("vec %0d: pc=%h req=%0b flush=%0b/%0b mis=%0b cnt=%0d", i,
                     a_pc, a_req, a_fif, a_fid, a_mis, a_cnt);
            check($sformatf("v%0d pc", i),       a_pc,                 vecs[i].pc);
            check($sformatf("v%0d pc_plus4", i), a_pc_plus4,           vecs[i].pc + 32'd4);
            check($sformatf("v%0d imem_req", i), 32'(a_req),           32'(vecs[i].req));
            check($sformatf("v%0d flush_if", i), 32'(a_fif),           32'(vecs[i].flush));
            check($sformatf("v%0d flush_id", i), 32'(a_fid),           32'(vecs[i].flush));
            check($sformatf("v%0d misalign", i), 32'(a_mis),           32'(vecs[i].mis));
            check($sformatf("v%0d cnt", i),      32'(a_cnt),           32'(vecs[i].cnt));
        end

        // Reset of the narrow instance: RESET_PC low bits forced to zero.
        drive(1, 0, 0, 0, 1, 32'h0);
        $display("reset: b_pc=%h b_req=%0b b_cnt=%0d", b_pc, b_req, b_cnt);
        check("b reset pc", b_pc, 32'h0000_1000);
        check("b reset req", 32'(b_req), 32'd0);
        check("b reset cnt", 32'(b_cnt), 32'd0);
        drive(0, 0, 0, 0, 1, 32'h0);
        check("b boot->fetch pc", b_pc, 32'h0000_1000);
        drive(0, 0, 0, 0, 1, 32'h0);
        check("b fetch pc", b_pc, 32'h0000_1004);

        // Four redirects two cycles apart; a branch in each REDIRECT cycle is ignored.
        for (int k = 0; k < 4; k++) begin
            logic [31:0] t;
            logic [31:0] exp_b;
            t = 32'h40 * (k + 1);
            exp_b = (k + 1 > 3) ? 32'd3 : 32'(k + 1);
            drive(0, 1, 0, 0, 1, t);
            $display("redirect %0d: b_pc=%h b_cnt=%0d a_cnt=%0d", k, b_pc, b_cnt, a_cnt);
            check($sformatf("sat%0d b_pc", k),  b_pc,        t);
            check($sformatf("sat%0d b_cnt", k), 32'(b_cnt),  exp_b);
            check($sformatf("sat%0d a_cnt", k), 32'(a_cnt),  32'(k + 1));
            check($sformatf("sat%0d b_flush", k), 32'(b_fif), 32'd1);
            drive(0, 1, 0, 0, 1, 32'h800);
            $display("ignored %0d: b_pc=%h b_cnt=%0d", k, b_pc, b_cnt);
            check($sformatf("ign%0d b_pc", k),    b_pc,       t + 32'd4);
            check($sformatf("ign%0d b_cnt", k),   32'(b_cnt), exp_b);
            check($sformatf("ign%0d b_flush", k), 32'(b_fif), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
